// File: rtl/data_ram_ws_pkg.sv
// Shared definitions for the wait-stated data RAM: bus widths, wait-counter
// width and the access FSM state encoding.
package data_ram_ws_pkg;

    localparam int BUS_W = 32;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram_ws_ctrl.sv
// Access sequencer: accepts a request in IDLE, counts out the wait states and
// raises a one-cycle fire strobe on the edge that performs the access.
module ws_ctrl
    import data_ram_ws_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic fire,
    output logic busy
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = WAIT;
                cnt_nxt   = CNT_W'(WAIT_CYCLES);
            end
            WAIT: if (cnt != '0) begin
                cnt_nxt = cnt - 1'b1;
            end else begin
                fire      = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // synchronous abort: drops any pending access without firing
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            fire      = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/data_ram_ws.sv
// Byte-laned 32-bit RAM with a fixed number of wait states per access.
// The request is captured at accept; the access happens on the fire edge.
module data_ram_ws
    import data_ram_ws_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_i,
    input  logic             we_i,
    input  logic [BUS_W-1:0] addr_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [BUS_W-1:0] data_i,
    output logic [BUS_W-1:0] data_o,
    output logic             ack_o,
    output logic             busy_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0] bank0 [DEPTH];
    logic [7:0] bank1 [DEPTH];
    logic [7:0] bank2 [DEPTH];
    logic [7:0] bank3 [DEPTH];

    logic                  we_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [SEL_W-1:0]      sel_q;
    logic [BUS_W-1:0]      data_q;
    logic                  fire;
    logic                  accept;
    logic                  unused_addr;

    // byte offset and bits above the array size do not select storage
    assign unused_addr = ^{addr_i[BUS_W-1:DEPTH_LOG2+2], addr_i[1:0]};
    assign accept      = ce_i && !busy_o;

    ws_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (ce_i),
        .clear (1'b0),
        .fire  (fire),
        .busy  (busy_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            sel_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            we_q   <= we_i;
            addr_q <= addr_i[DEPTH_LOG2+1:2];
            sel_q  <= sel_i;
            data_q <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (fire && we_q) begin
            if (sel_q[0]) bank0[addr_q] <= data_q[7:0];
            if (sel_q[1]) bank1[addr_q] <= data_q[15:8];
            if (sel_q[2]) bank2[addr_q] <= data_q[23:16];
            if (sel_q[3]) bank3[addr_q] <= data_q[31:24];
        end
    end

    // data_o is only non-zero during the ack cycle of a read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o  <= fire;
            data_o <= (fire && !we_q) ?
                      {bank3[addr_q], bank2[addr_q], bank1[addr_q], bank0[addr_q]} : '0;
        end
    end

endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: a WAIT_CYCLES=2 instance checked through a read-data
// scoreboard, and a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_data_ram_ws;

    localparam int W2 = 2;

    logic        clk;
    logic        rst;
    logic        ce, we;
    logic [31:0] addr, din, dout;
    logic [3:0]  sel;
    logic        ack, busy;

    logic        ce0, we0;
    logic [31:0] addr0, din0, dout0;
    logic [3:0]  sel0;
    logic        ack0, busy0;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_q[$];

    data_ram_ws #(.DEPTH_LOG2(10), .WAIT_CYCLES(W2)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(din), .data_o(dout), .ack_o(ack), .busy_o(busy)
    );

    data_ram_ws #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0), .sel_i(sel0),
        .data_i(din0), .data_o(dout0), .ack_o(ack0), .busy_o(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: every ack pops one expected data_o; outside ack data_o must be 0
    always @(negedge clk) begin
        if (rst) begin
            if (ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: data_o=%h, no access outstanding", dout);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        fails++;
                        $display("FAIL ack_data: got %h expected %h", dout, e);
                    end
                end
            end else begin
                checks++;
                if (dout !== 32'h0) begin
                    fails++;
                    $display("FAIL idle_data: got %h expected 00000000", dout);
                end
            end
        end
    end

    // lat = negedges after the accept-edge setup until ack is seen (ack rises at E0+W+1)
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] e, output int lat);
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; sel = s; din = d;
        exp_q.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 20);
        ce = 1'b0;
        if (!ack) void'(exp_q.pop_back());
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_w2: ack=%b busy=%b data=%h expected 0 0 0", ack, busy, dout);
        end
        checks++;
        if (ack0 !== 1'b0 || busy0 !== 1'b0 || dout0 !== 32'h0) begin
            fails++;
            $display("FAIL reset_w0: ack=%b busy=%b data=%h expected 0 0 0", ack0, busy0, dout0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        access(1'b1, 32'h0, 4'hF, 32'h44556677, 32'h0, lat);
        checks++;
        if (lat !== W2 + 2) begin
            fails++;
            $display("FAIL write_latency: got %0d expected %0d", lat, W2 + 2);
        end
        access(1'b0, 32'h0, 4'hF, 32'h0, 32'h44556677, lat);
        checks++;
        if (lat !== W2 + 2) begin
            fails++;
            $display("FAIL read_latency: got %0d expected %0d", lat, W2 + 2);
        end
        checks++;
        if (dut.bank3[0] !== 8'h44) begin
            fails++;
            $display("FAIL bank3_lane: got %h expected 44", dut.bank3[0]);
        end
    endtask

    task automatic test_sel();
        int lat;
        access(1'b1, 32'h4, 4'hF, 32'hAABBCCDD, 32'h0, lat);
        access(1'b1, 32'h4, 4'b0001, 32'h000000FF, 32'h0, lat);
        access(1'b0, 32'h4, 4'h0, 32'h0, 32'hAABBCCFF, lat);
        access(1'b1, 32'h4, 4'b0110, 32'h11223344, 32'h0, lat);
        access(1'b0, 32'h4, 4'hF, 32'h0, 32'hAA2233FF, lat);
    endtask

    task automatic test_zero_sel();
        int lat;
        access(1'b1, 32'h4, 4'b0000, 32'hFFFFFFFF, 32'h0, lat);
        checks++;
        if (lat !== W2 + 2) begin
            fails++;
            $display("FAIL zero_sel_ack: latency %0d expected %0d", lat, W2 + 2);
        end
        access(1'b0, 32'h4, 4'hF, 32'h0, 32'hAA2233FF, lat);
    endtask

    task automatic test_wrap();
        int lat;
        access(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0, lat);
        access(1'b0, 32'h0, 4'hF, 32'h0, 32'hDEADBEEF, lat);
        access(1'b0, 32'h3, 4'h0, 32'h0, 32'hDEADBEEF, lat);
        checks++;
        if (dut.bank0[0] !== 8'hEF) begin
            fails++;
            $display("FAIL wrap_bank0: got %h expected ef", dut.bank0[0]);
        end
    endtask

    task automatic test_capture();
        int lat;
        access(1'b1, 32'h14, 4'hF, 32'h0BADCAFE, 32'h0, lat);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; din = 32'h11111111;
        exp_q.push_back(32'h0);
        @(negedge clk);
        addr = 32'h14; din = 32'h22222222; sel = 4'h0; we = 1'b0; ce = 1'b0;
        lat = 1;
        while (!ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== W2 + 2) begin
            fails++;
            $display("FAIL capture_ack: latency %0d expected %0d", lat, W2 + 2);
        end
        if (!ack) void'(exp_q.pop_back());
        access(1'b0, 32'h10, 4'hF, 32'h0, 32'h11111111, lat);
        access(1'b0, 32'h14, 4'hF, 32'h0, 32'h0BADCAFE, lat);
    endtask

    task automatic test_abort();
        int lat;
        access(1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 32'h0, lat);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h8; sel = 4'hF; din = 32'h12345678;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0 || dout !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: busy=%b ack=%b data=%h expected 0 0 0", busy, ack, dout);
        end
        ce = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin
                fails++;
                $display("FAIL abort_ack: cycle %0d ack=%b expected 0", i, ack);
            end
        end
        access(1'b0, 32'h8, 4'hF, 32'h0, 32'hCAFEF00D, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; sel0 = 4'hF; din0 = 32'h5A5AA5A5;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack0 && lat < 20);
        checks++;
        if (lat !== 2 || dout0 !== 32'h0) begin
            fails++;
            $display("FAIL w0_write: latency %0d data %h expected 2 00000000", lat, dout0);
        end
        ce0 = 1'b0;
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== ((i % 3) == 2) || busy0 !== ((i % 3) != 0)) begin
                fails++;
                $display("FAIL b2b_timing: cycle %0d ack=%b busy=%b expected %b %b",
                         i, ack0, busy0, (i % 3) == 2, (i % 3) != 0);
            end
            if ((i % 3) == 2) begin
                checks++;
                if (dout0 !== 32'h5A5AA5A5) begin
                    fails++;
                    $display("FAIL b2b_data: cycle %0d got %h expected 5a5aa5a5", i, dout0);
                end
            end
            if (i == 8) ce0 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        ce = 1'b0; we = 1'b0; addr = '0; sel = '0; din = '0;
        ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; din0 = '0;
        test_reset();
        test_basic();
        test_sel();
        test_zero_sel();
        test_wrap();
        test_capture();
        test_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected acks never seen", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
